// File: rtl/core_pkg.sv
// Shared core types and defaults for the fetch/decode boundary.
// Holds widths, the NOP bubble word and the stage occupancy encoding.
package core_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;

  // ADDI x0,x0,0
  localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_ILEN-1:0] insn;
    logic [DEF_XLEN-1:0] pc;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic fetch_pkt_t mk_pkt(
    input logic [DEF_ILEN-1:0] insn,
    input logic [DEF_XLEN-1:0] pc
  );
    fetch_pkt_t p;
    p.insn = insn;
    p.pc   = pc;
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Single valid+payload holding register with load and clear.
// Clear drops valid and replaces the CLR_MASK bits with RST_VAL.
module pipe_skid_entry #(
  parameter int           W        = 64,
  parameter logic [W-1:0] RST_VAL  = '0,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = (data_q & ~CLR_MASK) | (RST_VAL & CLR_MASK);
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID stage: valid/ready handshake with a 2-entry skid buffer.
// Optional perf counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_pipe_reg
  import core_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              ILEN     = DEF_ILEN,
  parameter logic [ILEN-1:0] NOP_INSN = ILEN'(DEF_NOP_INSN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [ILEN-1:0] up_insn,
  input  logic [XLEN-1:0] up_pc,
  input  logic            flush,
  output logic            dn_valid,
  input  logic            dn_ready,
  output logic [ILEN-1:0] dn_insn,
  output logic [XLEN-1:0] dn_pc,
  output logic [1:0]      occupancy
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  localparam int W = ILEN + XLEN;

  // Clearing main swaps the insn field for NOP but keeps the PC.
  localparam logic [W-1:0] MAIN_RST  = {NOP_INSN, {XLEN{1'b0}}};
  localparam logic [W-1:0] MAIN_MASK = {{ILEN{1'b1}}, {XLEN{1'b0}}};

  occ_e state_q, state_d;

  logic         main_valid, skid_valid;
  logic [W-1:0] main_q, skid_q, main_d, up_pkt;
  logic         main_load, main_clr;
  logic         skid_load, skid_clr;
  logic         push, pop;

  assign up_pkt = {up_insn, up_pc};
  assign push   = up_valid & up_ready;
  assign pop    = main_valid & dn_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = up_pkt;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            state_d   = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (pop && push) begin
            main_load = 1'b1;
          end else if (pop) begin
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
          end else if (push) begin
            state_d   = OCC_TWO;
            skid_load = 1'b1;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            state_d   = OCC_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          state_d  = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  pipe_skid_entry #(
    .W        (W),
    .RST_VAL  (MAIN_RST),
    .CLR_MASK (MAIN_MASK)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_skid_entry #(
    .W        (W),
    .RST_VAL  ('0),
    .CLR_MASK ('0)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (up_pkt),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign up_ready  = ~skid_valid;
  assign dn_valid  = main_valid;
  assign dn_insn   = main_q[W-1:XLEN];
  assign dn_pc     = main_q[XLEN-1:0];
  assign occupancy = state_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_d, stall_q;
  logic [31:0] bubble_d, bubble_q;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_valid && !dn_ready) stall_d = stall_q + 32'd1;
    if (flush && (main_valid || skid_valid)) bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline stage with valid/ready handshake and a 2-entry skid buffer. It carries the fetched instruction word and its PC from fetch to decode. Branch flush replaces held contents with a NOP bubble. It decouples the upstream ready from the downstream ready, so there is no combinational ready path through the stage.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction word width in bits.
- NOP_INSN, 32'h0000_0013 (ADDI x0,x0,0), word presented on dn_insn whenever the stage holds no valid instruction; width ILEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- up_valid  in  1  fetch presents an instruction.
- up_ready  out  1  stage can accept; registered, equals !skid_valid.
- up_insn  in  ILEN  fetched instruction.
- up_pc  in  XLEN  PC of up_insn.
- flush  in  1  branch/redirect kill; synchronous.
- dn_valid  out  1  main entry valid.
- dn_ready  in  1  decode accepts this cycle.
- dn_insn  out  ILEN  main instruction, or NOP_INSN when !dn_valid.
- dn_pc  out  XLEN  main PC; holds its last value when invalid.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset, asynchronous: main_valid=0, skid_valid=0, dn_insn=NOP_INSN, dn_pc=0, up_ready=1, occupancy=0.
- Transfers: push = up_valid & up_ready; pop = dn_valid & dn_ready.
- States, encoded by occupancy:
  - EMPTY(0): push -> ONE; main loads up_*.
  - ONE(1), pop & push -> ONE; main loads up_*.
  - ONE(1), pop & !push -> EMPTY.
  - ONE(1), !pop & push -> TWO; skid loads up_*.
  - ONE(1), !pop & !push -> hold.
  - TWO(2), pop -> ONE; main loads skid, skid clears. up_ready is 0 in TWO, so push is impossible.
  - TWO(2), !pop -> hold; main and skid stable.
- Ordering: strict FIFO; the skid entry always issues after main.
- Latency: push to dn_valid is 1 cycle when EMPTY. There is no combinational path from up_* to dn_*.
- up_ready is a registered function of state only. up_valid asserted while up_ready=0 is ignored; upstream must hold the request.
- Flush has priority over push and pop in the same cycle. Next edge: main_valid=0, skid_valid=0, dn_insn=NOP_INSN, dn_pc unchanged, occupancy=0.
  - Any simultaneous push is discarded.
  - A simultaneous pop still counts as consumed by decode; decode owns the kill of that instruction.
- Flush held high for multiple cycles keeps the stage EMPTY, with up_ready=1.
- Whenever dn_valid=0, dn_insn is forced to NOP_INSN.
- dn_* and occupancy come straight from flops.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- No width arithmetic beyond the 2-bit occupancy, which never exceeds 2.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0], incremented each cycle dn_valid & !dn_ready, and bubble_cnt[31:0], incremented once per flush cycle that kills at least one valid entry.
  - Both counters wrap at 2^32.
  - Both reset to 0 asynchronously on rst.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package core_pkg holds the XLEN/ILEN defaults, the NOP_INSN constant, and a packed struct fetch_pkt_t {insn, pc}.
- One natural sub-module, pipe_skid_entry: a single valid+payload holding register with load/clear. It is instantiated twice, for main and skid.
- Control (state and up_ready) lives in the top module.

Test Plan:
- Reset: assert rst mid-stream with 2 entries held -> same cycle dn_valid=0, dn_insn=0x00000013, up_ready=1, occupancy=0.
- Streaming: dn_ready=1, push PCs 0x0, 0x4, 0x8 on consecutive cycles -> same PCs appear on dn_pc one cycle later each, with no bubbles.
- Backpressure: dn_ready=0, push PC 0x10 then 0x14 -> occupancy=2, up_ready=0; 0x18 held on input is not accepted. Release dn_ready -> 0x10, 0x14, 0x18 exit in order.
- Flush with full buffer: occupancy=2, flush=1 together with up_valid (PC 0x20) -> next cycle dn_valid=0, dn_insn=NOP_INSN, occupancy=0; 0x20 never appears.
- Flush with pop: occupancy=1, dn_ready=1, flush=1 -> pop counted, stage empty next cycle; bubble_cnt=1 when IF_ID_PERF_CNT_EN is defined.
- Stall count (IF_ID_PERF_CNT_EN defined): hold dn_ready=0 for 5 cycles with dn_valid=1 -> stall_cnt=5.
